// File: rtl/uart2aging_if.sv
// uart2aging_if: UART byte strobe in, reassembled aging frame and status out.
interface uart2aging_if;
    logic [7:0]  UartData_i;
    logic        UartValid_i;
    logic [19:0] Data_o_alu;
    logic [19:0] Data_o_iu;
    logic        Valid_o;
    logic        Sync_o;
    logic [7:0]  ErrCnt_o;
    modport master (output UartData_i, UartValid_i, input Data_o_alu, Data_o_iu, Valid_o, Sync_o, ErrCnt_o);
    modport slave (input UartData_i, UartValid_i, output Data_o_alu, Data_o_iu, Valid_o, Sync_o, ErrCnt_o);
endinterface

// File: rtl/uart2aging.sv
// uart2aging: reassembles tagged-nibble aging-sensor frames into 20-bit ALU/IU values.
// Define UART2AGING_ERRCNT_EN to build the saturating sequence-error counter.
module uart2aging #(
    parameter int TIMEOUT_CYC = 100000
) (
    input logic        clk,
    input logic        rst,
    uart2aging_if.slave u
);
    localparam int IW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
    typedef enum logic {HUNT, RECV} state_t;
    state_t        state, state_n;
    logic [3:0]    exp_q, exp_n;
    logic [39:0]   shadow;
    logic [IW-1:0] idle, idle_n;
    logic          accept, commit, expire;
    logic [3:0]    tag, nib;
    assign tag = u.UartData_i[7:4];
    assign nib = u.UartData_i[3:0];
    assign expire = TIMEOUT_CYC != 0 && state == RECV && idle == IW'(TIMEOUT_CYC - 1);
    assign u.Sync_o = state == RECV;
    always_comb begin
        state_n = state;
        exp_n = exp_q;
        accept = 1'b0;
        commit = 1'b0;
        idle_n = (state == RECV && !u.UartValid_i) ? idle + 1'b1 : '0;
        if (u.UartValid_i) begin
            if (tag == 4'd0) begin
                accept = 1'b1;
                exp_n = 4'd1;
                state_n = RECV;
            end else if (tag == 4'd1) begin
                accept = 1'b1;
                exp_n = 4'd2;
                state_n = RECV;
            end else if (state == RECV && tag == exp_q) begin
                accept = 1'b1;
                commit = tag == 4'd9;
                exp_n = tag == 4'd9 ? 4'd1 : exp_q + 4'd1;
            end else if (state == RECV) begin
                state_n = HUNT;
            end
        end else if (expire) begin
            state_n = HUNT;
            idle_n = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
            exp_q <= '0;
            idle <= '0;
            shadow <= '0;
            u.Data_o_alu <= '0;
            u.Data_o_iu <= '0;
            u.Valid_o <= 1'b0;
        end else begin
            state <= state_n;
            exp_q <= exp_n;
            idle <= idle_n;
            u.Valid_o <= commit;
            if (accept) shadow[{tag, 2'b00} +: 4] <= nib;
            // the final IU nibble bypasses the shadow so both words commit together
            if (commit) begin
                u.Data_o_alu <= shadow[19:0];
                u.Data_o_iu <= {nib, shadow[35:20]};
            end
        end
    end
`ifdef UART2AGING_ERRCNT_EN
    logic err;
    assign err = u.UartValid_i && state == RECV && tag != 4'd0 && (tag == 4'd1 ? exp_q != 4'd1 : tag != exp_q);
    always_ff @(posedge clk) begin
        if (rst) u.ErrCnt_o <= '0;
        else if (err && u.ErrCnt_o != 8'hFF) u.ErrCnt_o <= u.ErrCnt_o + 8'd1;
    end
`else
    assign u.ErrCnt_o = '0;
`endif
endmodule

// File: tb/tb_uart2aging.sv
// tb_uart2aging: directed and randomized checks of uart2aging against a rule-level frame model.
module tb_uart2aging;
    localparam int TO = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_pass = 0;
    uart2aging_if u ();
    uart2aging #(.TIMEOUT_CYC(TO)) dut (.clk(clk), .rst(rst), .u(u.slave));
    always #5 clk = ~clk;

    bit         m_recv;
    int         m_exp, m_idle, m_err;
    int         m_nib [10];
    logic [19:0] m_alu, m_iu;
    bit         m_valid;

    function automatic logic [19:0] pack(input int base);
        logic [19:0] r = '0;
        for (int i = 0; i < 5; i++) r = r | (20'(m_nib[base + i]) << (4 * i));
        return r;
    endfunction

    function automatic logic [7:0] exp_err();
`ifdef UART2AGING_ERRCNT_EN
        return 8'(m_err);
`else
        return 8'd0;
`endif
    endfunction

    task automatic model_reset();
        m_recv = 0; m_exp = 0; m_idle = 0; m_err = 0; m_valid = 0;
        m_alu = '0; m_iu = '0;
        for (int i = 0; i < 10; i++) m_nib[i] = 0;
    endtask

    task automatic cycle(input bit v, input logic [7:0] b);
        int t, n;
        bit ok, fin;
        u.UartValid_i = v;
        u.UartData_i = b;
        @(negedge clk);
        t = int'(b[7:4]); n = int'(b[3:0]); ok = 0; fin = 0; m_valid = 0;
        if (v) begin
            m_idle = 0;
            if (t == 0) begin ok = 1; m_exp = 1; m_recv = 1; end
            else if (t == 1) begin
                if (m_recv && m_exp != 1) m_err = m_err < 255 ? m_err + 1 : 255;
                ok = 1; m_exp = 2; m_recv = 1;
            end else if (m_recv && t == m_exp) begin
                ok = 1; fin = t == 9; m_exp = fin ? 1 : t + 1;
            end else if (m_recv) begin
                m_err = m_err < 255 ? m_err + 1 : 255; m_recv = 0;
            end
            if (ok) m_nib[t] = n;
            if (fin) begin m_alu = pack(0); m_iu = pack(5); m_valid = 1; end
        end else if (m_recv) begin
            m_idle++;
            if (m_idle == TO) begin m_recv = 0; m_idle = 0; end
        end
    endtask

    task automatic do_reset(input bit v, input logic [7:0] b);
        rst = 1'b1;
        u.UartValid_i = v;
        u.UartData_i = b;
        @(negedge clk);
        rst = 1'b0;
        u.UartValid_i = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset(1'b0, 8'h00);
        n_chk += 5;
        if (u.Data_o_alu !== 20'h0) $display("FAIL reset_alu got %h want 0", u.Data_o_alu); else n_pass++;
        if (u.Data_o_iu !== 20'h0) $display("FAIL reset_iu got %h want 0", u.Data_o_iu); else n_pass++;
        if (u.Valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", u.Valid_o); else n_pass++;
        if (u.Sync_o !== 1'b0) $display("FAIL reset_sync got %b want 0", u.Sync_o); else n_pass++;
        if (u.ErrCnt_o !== 8'h0) $display("FAIL reset_err got %h want 0", u.ErrCnt_o); else n_pass++;
    endtask

    task automatic test_frame(input logic [7:0] seq [], input logic [19:0] alu, input logic [19:0] iu, input string nm);
        int pulses = 0;
        logic [7:0] e0 = exp_err();
        foreach (seq[i]) begin
            cycle(1'b1, seq[i]);
            pulses += int'(u.Valid_o);
        end
        n_chk += 5;
        if (u.Data_o_alu !== alu) $display("FAIL %s_alu got %h want %h", nm, u.Data_o_alu, alu); else n_pass++;
        if (u.Data_o_iu !== iu) $display("FAIL %s_iu got %h want %h", nm, u.Data_o_iu, iu); else n_pass++;
        if (u.Valid_o !== 1'b1) $display("FAIL %s_valid got %b want 1", nm, u.Valid_o); else n_pass++;
        if (pulses != 1) $display("FAIL %s_pulses got %0d want 1", nm, pulses); else n_pass++;
        if (u.ErrCnt_o !== e0) $display("FAIL %s_err got %h want %h", nm, u.ErrCnt_o, e0); else n_pass++;
        cycle(1'b0, 8'h00);
        n_chk += 2;
        if (u.Valid_o !== 1'b0) $display("FAIL %s_valid_drop got %b want 0", nm, u.Valid_o); else n_pass++;
        if (u.Data_o_alu !== alu) $display("FAIL %s_hold got %h want %h", nm, u.Data_o_alu, alu); else n_pass++;
    endtask

    task automatic test_resync();
        logic [7:0] pre [] = '{8'h11, 8'h22, 8'h33};
        logic [19:0] alu0 = u.Data_o_alu;
        foreach (pre[i]) cycle(1'b1, pre[i]);
        cycle(1'b1, 8'h55);
        n_chk += 3;
        if (u.Sync_o !== 1'b0) $display("FAIL resync_sync got %b want 0", u.Sync_o); else n_pass++;
        if (u.ErrCnt_o !== exp_err()) $display("FAIL resync_err got %h want %h", u.ErrCnt_o, exp_err()); else n_pass++;
        if (u.Valid_o !== 1'b0) $display("FAIL resync_valid got %b want 0", u.Valid_o); else n_pass++;
        for (int t = 2; t <= 9; t++) begin
            cycle(1'b1, 8'(t * 16 + t));
            n_chk += 2;
            if (u.Sync_o !== 1'b0) $display("FAIL hunt_ignore_sync tag %0d got %b want 0", t, u.Sync_o); else n_pass++;
            if (u.Data_o_alu !== alu0) $display("FAIL hunt_ignore_alu tag %0d got %h want %h", t, u.Data_o_alu, alu0); else n_pass++;
        end
        cycle(1'b1, 8'h1C);
        n_chk += 2;
        if (u.Sync_o !== 1'b1) $display("FAIL resync_tag1 got %b want 1", u.Sync_o); else n_pass++;
        if (u.ErrCnt_o !== exp_err()) $display("FAIL resync_tag1_err got %h want %h", u.ErrCnt_o, exp_err()); else n_pass++;
    endtask

    task automatic test_timeout();
        logic [7:0] e0;
        do_reset(1'b0, 8'h00);
        cycle(1'b1, 8'h15); cycle(1'b1, 8'h26);
        e0 = exp_err();
        for (int i = 0; i < TO - 1; i++) cycle(1'b0, 8'h00);
        n_chk++;
        if (u.Sync_o !== 1'b1) $display("FAIL timeout_early got %b want 1", u.Sync_o); else n_pass++;
        cycle(1'b0, 8'h00);
        n_chk += 2;
        if (u.Sync_o !== 1'b0) $display("FAIL timeout_expire got %b want 0", u.Sync_o); else n_pass++;
        if (u.ErrCnt_o !== e0) $display("FAIL timeout_err got %h want %h", u.ErrCnt_o, e0); else n_pass++;
        cycle(1'b1, 8'h15); cycle(1'b1, 8'h26);
        for (int i = 0; i < TO - 1; i++) cycle(1'b0, 8'h00);
        cycle(1'b1, 8'h37);
        n_chk += 2;
        if (u.Sync_o !== 1'b1) $display("FAIL timeout_edge_byte got %b want 1", u.Sync_o); else n_pass++;
        if (u.ErrCnt_o !== e0) $display("FAIL timeout_edge_err got %h want %h", u.ErrCnt_o, e0); else n_pass++;
    endtask

    task automatic test_midframe_reset();
        for (int t = 1; t <= 7; t++) cycle(1'b1, 8'(t * 16 + 4'hA));
        do_reset(1'b1, 8'h8A);
        n_chk += 4;
        if (u.Data_o_alu !== 20'h0 || u.Data_o_iu !== 20'h0) $display("FAIL midreset_data got %h/%h want 0/0", u.Data_o_alu, u.Data_o_iu); else n_pass++;
        if (u.Valid_o !== 1'b0) $display("FAIL midreset_valid got %b want 0", u.Valid_o); else n_pass++;
        if (u.Sync_o !== 1'b0) $display("FAIL midreset_sync got %b want 0", u.Sync_o); else n_pass++;
        if (u.ErrCnt_o !== 8'h0) $display("FAIL midreset_err got %h want 0", u.ErrCnt_o); else n_pass++;
        cycle(1'b1, 8'h9A);
        n_chk++;
        if (u.Valid_o !== 1'b0 || u.Sync_o !== 1'b0) $display("FAIL midreset_tail got v%b s%b want v0 s0", u.Valid_o, u.Sync_o); else n_pass++;
        do_reset(1'b0, 8'h00);
        cycle(1'b1, 8'h13);
        n_chk++;
        if (u.Sync_o !== 1'b1) $display("FAIL first_strobe got %b want 1", u.Sync_o); else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset(1'b0, 8'h00);
        for (int i = 0; i < 260; i++) begin cycle(1'b1, 8'h11); cycle(1'b1, 8'hF0); end
        n_chk += 2;
        if (u.ErrCnt_o !== exp_err()) $display("FAIL saturate got %h want %h", u.ErrCnt_o, exp_err()); else n_pass++;
        if (m_err != 255) $display("FAIL saturate_model_errs got %0d want 255", m_err); else n_pass++;
    endtask

    task automatic test_random();
        int commits = 0, bad = 0;
        logic [7:0] b;
        bit v;
        do_reset(1'b0, 8'h00);
        for (int i = 0; i < 3000; i++) begin
            int r = int'($urandom_range(0, 99));
            int t = r < 65 ? (m_exp == 0 ? 1 : m_exp) : r < 80 ? 1 : r < 85 ? 0 : int'($urandom_range(0, 15));
            v = $urandom_range(0, 3) != 0;
            b = {4'(t), 4'($urandom_range(0, 15))};
            if ($urandom_range(0, 199) == 0) for (int k = 0; k < TO + 2; k++) cycle(1'b0, 8'h00);
            cycle(v, b);
            commits += int'(m_valid);
            n_chk++;
            if (u.Data_o_alu !== m_alu || u.Data_o_iu !== m_iu || u.Valid_o !== m_valid || u.Sync_o !== m_recv || u.ErrCnt_o !== exp_err()) begin
                bad++;
                if (bad < 10) $display("FAIL random cyc %0d got alu %h iu %h v%b s%b e%h want alu %h iu %h v%b s%b e%h",
                    i, u.Data_o_alu, u.Data_o_iu, u.Valid_o, u.Sync_o, u.ErrCnt_o, m_alu, m_iu, m_valid, m_recv, exp_err());
            end else n_pass++;
        end
        n_chk++;
        if (commits < 5) $display("FAIL random_commits got %0d want >=5", commits); else n_pass++;
    endtask

    initial begin
        u.UartValid_i = 1'b0;
        u.UartData_i = 8'h00;
        model_reset();
        @(negedge clk);
        test_reset();
        test_frame('{8'h0A, 8'h1B, 8'h2C, 8'h3D, 8'h4E, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99}, 20'hEDCBA, 20'h98765, "frame0");
        test_frame('{8'h11, 8'h22, 8'h33, 8'h44, 8'h50, 8'h61, 8'h72, 8'h83, 8'h94}, 20'h4321A, 20'h43210, "frame_loop");
        test_resync();
        test_timeout();
        test_midframe_reset();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart2aging.md
UART2AGING -- requirements
Module: uart2aging

Interface
REQ-001 Parameter TIMEOUT_CYC, default 100000, gives the idle cycles allowed between bytes while in RECV; a value of 0 disables the timeout.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 UartData_i  input  8  received UART byte: [7:4] is the tag, [3:0] is the nibble.
REQ-005 UartValid_i  input  1  one-cycle strobe; UartData_i is valid in that cycle.
REQ-006 Data_o_alu  output  20  last committed ALU aging value.
REQ-007 Data_o_iu  output  20  last committed IU aging value.
REQ-008 Valid_o  output  1  one-cycle pulse when a new frame is committed.
REQ-009 Sync_o  output  1  high while the state is RECV.
REQ-010 ErrCnt_o  output  8  saturating count of sequence errors.

Function
REQ-011 The block SHALL reassemble the frames produced by the aging-sensor transmitter. Tag t in 0..4 carries ALU bits [4t+3:4t]. Tag t in 5..9 carries IU bits [4(t-5)+3:4(t-5)].
REQ-012 The transmitter sends tag 0 only once after its reset, then loops tags 1..9 forever. The receiver SHALL therefore treat tag 1 after tag 9 as a normal frame start.
REQ-013 The block SHALL have two states, HUNT and RECV, plus a 4-bit expected-tag register Exp.
REQ-014 Every accepted byte SHALL write its nibble into a 40-bit shadow register at the slot given by its tag. Discarded bytes SHALL NOT write the shadow.
REQ-015 Tag 0 in any state SHALL be accepted, set Exp=1, enter RECV, and not count as an error.
REQ-016 Tag 1 in HUNT, or in RECV with Exp=1, SHALL be accepted, set Exp=2, and enter or stay in RECV.
REQ-017 Tag 1 in RECV with Exp≠1 SHALL be accepted, set Exp=2, stay in RECV, and increment the error count.
REQ-018 In RECV, a tag equal to Exp (2..8) SHALL be accepted and set Exp=Exp+1.
REQ-019 In RECV, tag 9 with Exp=9 SHALL be accepted, set Exp=1, and commit the frame.
REQ-020 In RECV, any other tag (wrong sequence, or 10..15) SHALL be discarded, increment the error count, and go to HUNT.
REQ-021 In HUNT, tags 2..15 SHALL be discarded silently with no error.
REQ-022 Commit: on the cycle after the tag-9 strobe, Data_o_alu and Data_o_iu SHALL update together, with IU[19:16] taken from that final byte, and Valid_o SHALL be high for exactly that one cycle.
REQ-023 Data_o_alu and Data_o_iu SHALL hold between commits.
REQ-024 ALU[3:0] SHALL be taken from the most recent tag-0 byte; it is 0 if no tag-0 byte has been received since reset.
REQ-025 Timeout: in RECV, after TIMEOUT_CYC consecutive cycles with no strobe, the block SHALL go to HUNT with no error increment. The idle counter SHALL clear on every strobe and in HUNT.
REQ-026 If the timeout expiry and a strobe occur in the same cycle, the byte SHALL be processed and the timeout ignored.
REQ-027 ErrCnt_o SHALL saturate at 255.
REQ-028 Sync_o SHALL be registered and equal (state==RECV).

Reset
REQ-029 While rst is high at a clock edge, the following SHALL be set:
- state=HUNT, Exp=0
- shadow=0, Data_o_alu=0, Data_o_iu=0
- Valid_o=0, Sync_o=0, ErrCnt_o=0
- idle counter=0
REQ-030 Reset asserted mid-frame SHALL abandon the partial frame without a commit. A strobe in the same cycle as reset SHALL be ignored.
REQ-031 The first strobe SHALL be processed on the first edge after rst deasserts.

Configuration
REQ-032 Macro UART2AGING_ERRCNT_EN.
- Defined: the 8-bit saturating error counter per REQ-027.
- Undefined: no counter register; ErrCnt_o is tied to 0; all other behaviour is identical.

Verification
REQ-033 Reset, then bytes 0x0A,0x1B,0x2C,0x3D,0x4E,0x55,0x66,0x77,0x88,0x99 -> one cycle after the last byte: Data_o_alu=0xEDCBA, Data_o_iu=0x98765, one Valid_o pulse, ErrCnt_o=0.
REQ-034 Continue with 0x11,0x22,0x33,0x44,0x50,0x61,0x72,0x83,0x94 -> Data_o_alu=0x4321A (nibble 0 retained), Data_o_iu=0x43210, one Valid_o pulse, no error.
REQ-035 Mid-frame, after tags 1,2,3 send 0x55 -> discarded, ErrCnt_o=1, Sync_o=0, no commit; bytes with tags 2..9 then ignored until a tag-1 byte resynchronises.
REQ-036 TIMEOUT_CYC=16: send tags 1,2, then idle 16 cycles -> HUNT, Sync_o=0, ErrCnt_o unchanged; a byte on cycle 16 itself keeps RECV.
REQ-037 Assert rst after tag 7 of a frame -> all outputs 0, no Valid_o; build without UART2AGING_ERRCNT_EN and repeat REQ-035 -> ErrCnt_o stays 0.
